// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux select sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } mux_scan_state_t;

  localparam int MUX_SCAN_NCH   = 4;
  localparam int MUX_SCAN_SEL_W = 2;

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Loadable down-counter; done flags the last cycle of a settle window.
module settle_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // Count down to zero after each load, then rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == CNT_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 mux select, samples each channel after settling, offers the word on valid/ready.
// Define MUX_SCAN_AUTO_EN for free-running scans (start ignored, HOLD restarts directly).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] sel,
  input  logic       mux_o,
  output logic       busy,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [MUX_SCAN_SEL_W-1:0] LAST_SEL = MUX_SCAN_SEL_W'(MUX_SCAN_NCH - 1);

`ifdef MUX_SCAN_AUTO_EN
  localparam logic AUTO_EN = 1'b1;
`else
  localparam logic AUTO_EN = 1'b0;
`endif

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE_CYCLES must be in 1..255");
  end

  mux_scan_state_t             state_r, next_state_s;
  logic [MUX_SCAN_SEL_W-1:0]   sel_r;
  logic [MUX_SCAN_NCH-2:0]     asm_r;
  logic [MUX_SCAN_NCH-1:0]     data_r;
  logic                        valid_r;
  logic                        busy_r;
  logic                        load_s;
  logic                        done_s;

  settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .done     (done_s)
  );

  // Next-state and timer-load decode.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start || AUTO_EN) begin
          next_state_s = ST_SETTLE;
          load_s       = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (done_s) begin
          next_state_s = ST_SAMPLE;
        end else begin
          next_state_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (sel_r == LAST_SEL) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_SETTLE;
          load_s       = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ready && AUTO_EN) begin
          next_state_s = ST_SETTLE;
          load_s       = 1'b1;
        end else if (ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, select, assembly and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sel_r   <= 2'd0;
      asm_r   <= '0;
      data_r  <= 4'h0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (load_s) asm_r <= '0;
        end
        ST_SAMPLE: begin
          // The last channel goes straight into data, so asm_r only holds the first three.
          if (sel_r == LAST_SEL) begin
            data_r  <= {mux_o, asm_r};
            valid_r <= 1'b1;
            sel_r   <= 2'd0;
          end else begin
            asm_r[sel_r] <= mux_o;
            sel_r        <= sel_r + 2'd1;
          end
        end
        ST_HOLD: begin
          if (ready) begin
            valid_r <= 1'b0;
            if (load_s) asm_r <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sel   = sel_r;
  assign busy  = busy_r;
  assign data  = data_r;
  assign valid = valid_r;

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Select sequencer that sits directly upstream of the 4:1 mux: it drives the mux select, waits a programmable settle time per channel, samples the single mux output bit and assembles the four sampled bits into a word. The completed word is offered downstream on a valid/ready handshake. This turns the mux's one-bit combinational view into a registered 4-bit snapshot of its inputs for the rest of the Mimas V2 design.

## Interface
- `SETTLE_CYCLES`, default 2: cycles `sel` is held stable before each sample. Legal range is 1..255; 0 is an elaboration error.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  level-sampled request to begin one scan; honoured only in IDLE.
- `sel`  out  2  drives the mux select input.
- `mux_o`  in  1  mux output. Synchronous to `clk`; any switch synchronisation happens before the mux.
- `busy`  out  1  high whenever state is not IDLE.
- `data`  out  4  assembled word; `data[k]` is `mux_o` sampled while `sel==k`.
- `valid`  out  1  `data` holds a complete, unconsumed word.
- `ready`  in  1  downstream accepts the word.

## Operation
- **Reset values:** state IDLE, `sel=0`, `busy=0`, `data=4'h0`, `valid=0`. The internal shift register and settle counter are also cleared.
- **FSM states:** IDLE, SETTLE, SAMPLE, HOLD.
- **IDLE:**
  - `sel=0`.
  - If `start==1` at a clock edge: move to SETTLE, keep `sel=0`, load the settle counter with `SETTLE_CYCLES`, clear the internal assembly register.
- **SETTLE:**
  - The counter decrements each cycle.
  - When the counter reaches 1, move to SAMPLE. SETTLE therefore lasts exactly `SETTLE_CYCLES` cycles.
- **SAMPLE:** one cycle. At its closing edge, `asm[sel] <= mux_o`.
  - If `sel<3`: `sel <= sel+1`, reload the counter, return to SETTLE.
  - If `sel==3`: `data <= {mux_o, asm[2:0]}`, `valid <= 1`, `sel <= 0`, move to HOLD.
- **HOLD:**
  - `data` and `valid` stay stable until `valid & ready` is seen at an edge.
  - On that edge: `valid <= 0`, move to IDLE.
- **Ignored inputs:** `start` has no effect in SETTLE, SAMPLE or HOLD, and requests are not queued. `ready` has no effect outside HOLD.
- **`data` retention:** `data` is only updated on entry to HOLD. It keeps the last word through IDLE and through the following scan.
- **Width rules:** `sel` is a 2-bit counter and never wraps mid-scan, because it is reset to 0 explicitly. The counter width is `$clog2(SETTLE_CYCLES+1)`.

## Timing
- Each channel takes `SETTLE_CYCLES+1` cycles.
- `valid` rises exactly `4*(SETTLE_CYCLES+1)` edges after the edge that accepted `start`. For the default, that is 12.
- `ready` already high when `valid` rises: the handshake completes on the next edge, so `valid` is high for exactly one cycle.
- Back-to-back scans: the earliest new `start` is accepted one edge after the handshake, i.e. in IDLE.
- Reset mid-scan: `valid`, `busy` and `sel` fall asynchronously on `rst_n` falling. No partial word is ever presented.

## Configuration
- `MUX_SCAN_AUTO_EN` defined: free-running mode.
  - `start` is ignored.
  - IDLE behaves as if `start==1`, so the first scan begins on the first edge after reset release.
  - The handshake edge in HOLD goes directly to SETTLE (`sel=0`, counter loaded), skipping IDLE.
  - `busy` stays high except during the first cycle after reset.
- `MUX_SCAN_AUTO_EN` undefined: single-shot behaviour exactly as specified above.

## Structure
- Package `mux_scan_pkg` holds:
  - the state enum `mux_scan_state_t` (IDLE, SETTLE, SAMPLE, HOLD);
  - `MUX_SCAN_NCH = 4`;
  - `MUX_SCAN_SEL_W = 2`.
- One sub-module, `settle_timer`:
  - loadable down-counter with a `load` input and a `done` output;
  - `done` is high in the cycle its count equals 1.
- The FSM, assembly register and handshake stay in the top module.

## Test plan
- **Default scan:** model the mux with inputs `4'b1010`, pulse `start` → `sel` steps 0,1,2,3, each held 3 cycles; `valid` rises 12 edges after start with `data=4'hA`; with `ready=1`, `valid` falls on the next edge.
- **Backpressure:** hold `ready=0` for 20 cycles after `valid` → `data` stays `4'hA` and `valid` stays high; a `start` pulse during HOLD is ignored; raising `ready` gives one handshake, then IDLE.
- **Settle length:** `SETTLE_CYCLES=1`, inputs `4'b0110` → `valid` rises after 8 edges with `data=4'h6`; `mux_o` changed during SETTLE is not captured, only the SAMPLE-cycle value is.
- **Reset mid-scan:** assert `rst_n=0` while `sel==2` → `sel`, `valid` and `busy` go to 0 immediately and `data=0`; the next scan yields a correct word.
- **Auto mode:** with `MUX_SCAN_AUTO_EN` and `ready` tied high → `valid` pulses every 13 cycles (12 scan cycles plus 1 HOLD cycle) and `data` tracks input changes between scans.
